// File: rtl/width_combine_if.sv
// Valid/ready bundle for the narrow-to-wide packer.
// Write side: wr_data/wr_vld/wr_last in, wr_ready back.
// Read side:  rd_data/rd_vld/rd_last/rd_cnt out, rd_ready back.
// slave  : the packer's view (consumes elements, produces words).
// master : the surrounding logic's view (produces elements, consumes words).
interface width_combine_if #(
    parameter int DSIZE = 1,
    parameter int NSIZE = 8
);
    localparam int CW = $clog2(NSIZE + 1);

    logic [DSIZE-1:0]       wr_data;
    logic                   wr_vld;
    logic                   wr_ready;
    logic                   wr_last;
    logic [DSIZE*NSIZE-1:0] rd_data;
    logic                   rd_vld;
    logic                   rd_last;
    logic [CW-1:0]          rd_cnt;
    logic                   rd_ready;

    modport master (
        output wr_data, wr_vld, wr_last, rd_ready,
        input  wr_ready, rd_data, rd_vld, rd_last, rd_cnt
    );

    modport slave (
        input  wr_data, wr_vld, wr_last, rd_ready,
        output wr_ready, rd_data, rd_vld, rd_last, rd_cnt
    );
endinterface

// File: rtl/width_combine.sv
// Narrow-to-wide packer: gathers NSIZE DSIZE-bit elements (MSB lane first)
// into one DSIZE*NSIZE-bit word. wr_last flushes a partial word early; the
// word carries its element count and a packet-end flag.
// Ports:
//   clock : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : width_combine_if slave (wr_* element stream in, rd_* word out)
module width_combine #(
    parameter int DSIZE = 1,
    parameter int NSIZE = 8
) (
    input  logic           clock,
    input  logic           rst_n,
    width_combine_if.slave bus
);
    localparam int PW = $clog2(NSIZE);
    localparam int CW = $clog2(NSIZE + 1);
    localparam int WW = DSIZE * NSIZE;

    logic [WW-1:0] acc;
    logic [PW-1:0] point;
    logic [31:0]   pt;
    logic [WW-1:0] merged;

    logic [WW-1:0] rd_data_q;
    logic [CW-1:0] rd_cnt_q;
    logic          rd_vld_q;
    logic          rd_last_q;

    logic at_end;
    logic ends_word;
    logic wr_ready;
    logic accept;
    logic complete;

    assign at_end    = (point == PW'(NSIZE - 1));
    assign ends_word = at_end || bus.wr_last;
    // Only the element that finishes a word can be held off, and only while
    // the output register still holds an undrained word.
    assign wr_ready  = !(ends_word && rd_vld_q && !bus.rd_ready);
    assign accept    = bus.wr_vld && wr_ready;
    assign complete  = accept && ends_word;

    assign pt = 32'(point);

    // Accumulator with the incoming element placed at lane 'point'; lanes
    // after it are zero so a flushed partial word has clean low lanes.
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < NSIZE; i++) begin
            if (i < pt) begin
                merged[WW-1-DSIZE*i -: DSIZE] = acc[WW-1-DSIZE*i -: DSIZE];
            end else if (i == pt) begin
                merged[WW-1-DSIZE*i -: DSIZE] = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            point     <= '0;
            rd_data_q <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            if (complete) begin
                acc   <= '0;
                point <= '0;
            end else if (accept) begin
                acc   <= merged;
                point <= point + PW'(1);
            end

            // A new word loading in the same cycle as a drain keeps rd_vld
            // high, so back-to-back words leave no bubble.
            if (complete) begin
                rd_data_q <= merged;
                rd_cnt_q  <= CW'(point) + CW'(1);
                rd_last_q <= bus.wr_last;
                rd_vld_q  <= 1'b1;
            end else if (rd_vld_q && bus.rd_ready) begin
                rd_vld_q  <= 1'b0;
                rd_last_q <= 1'b0;
            end
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_cnt   = rd_cnt_q;
    assign bus.rd_vld   = rd_vld_q;
    assign bus.rd_last  = rd_last_q;
endmodule

// File: tb/tb_width_combine.sv
// Self-checking bench for width_combine with DSIZE=4, NSIZE=4.
module tb_width_combine;
    logic clock;
    logic rst_n;

    width_combine_if #(.DSIZE(4), .NSIZE(4)) bus ();

    width_combine #(.DSIZE(4), .NSIZE(4)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic wr_ready_s;

    typedef struct {
        logic [3:0]  d;
        logic        v;
        logic        l;
        logic        r;
        logic        ew;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ec;
        logic        el;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  cnt;
        logic        last;
    } word_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample wr_ready before the edge, return
    // just after the edge so registered outputs can be checked.
    task automatic drive(input logic [3:0] d, input logic v, input logic l, input logic r);
        bus.wr_data  = d;
        bus.wr_vld   = v;
        bus.wr_last  = l;
        bus.rd_ready = r;
        #3;
        wr_ready_s = bus.wr_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [2:0] c, input logic l);
        check({tag, " rd_vld"},  32'(bus.rd_vld),  32'(v));
        check({tag, " rd_data"}, 32'(bus.rd_data), 32'(d));
        check({tag, " rd_cnt"},  32'(bus.rd_cnt),  32'(c));
        check({tag, " rd_last"}, 32'(bus.rd_last), 32'(l));
    endtask

    vec_t  vecs [13];
    word_t src  [7];

    initial begin
        //            d     v  l  r   ew ev  ed        ec    el
        vecs[0]  = '{4'h1, 1, 0, 1,  1, 0, 16'h0000, 3'd0, 0};
        vecs[1]  = '{4'h2, 1, 0, 1,  1, 0, 16'h0000, 3'd0, 0};
        vecs[2]  = '{4'h3, 1, 0, 1,  1, 0, 16'h0000, 3'd0, 0};
        vecs[3]  = '{4'h4, 1, 0, 1,  1, 1, 16'h1234, 3'd4, 0};
        vecs[4]  = '{4'h5, 1, 0, 1,  1, 0, 16'h1234, 3'd4, 0};
        vecs[5]  = '{4'h6, 1, 1, 1,  1, 1, 16'h5600, 3'd2, 1};
        vecs[6]  = '{4'hA, 1, 1, 1,  1, 1, 16'hA000, 3'd1, 1};
        vecs[7]  = '{4'h0, 0, 0, 1,  1, 0, 16'hA000, 3'd1, 0};
        vecs[8]  = '{4'hF, 0, 1, 1,  1, 0, 16'hA000, 3'd1, 0};
        vecs[9]  = '{4'h7, 1, 0, 1,  1, 0, 16'hA000, 3'd1, 0};
        vecs[10] = '{4'h8, 1, 1, 1,  1, 1, 16'h7800, 3'd2, 1};
        vecs[11] = '{4'h0, 0, 0, 0,  1, 1, 16'h7800, 3'd2, 1};
        vecs[12] = '{4'h0, 0, 0, 1,  1, 0, 16'h7800, 3'd2, 0};

        // Serialized source words; short words always end a packet.
        src[0] = '{16'hCAFE, 3'd4, 0};
        src[1] = '{16'hBEEF, 3'd4, 1};
        src[2] = '{16'h3000, 3'd1, 1};
        src[3] = '{16'h4560, 3'd3, 1};
        src[4] = '{16'h7700, 3'd2, 1};
        src[5] = '{16'h0F0F, 3'd4, 0};
        src[6] = '{16'h1357, 3'd4, 1};

        rst_n        = 1'b0;
        bus.wr_data  = '0;
        bus.wr_vld   = 1'b0;
        bus.wr_last  = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_out("reset", 0, 16'h0000, 3'd0, 0);
        check("reset wr_ready", 32'(bus.wr_ready), 32'd1);
        rst_n = 1'b1;

        // Table: full word, short packet, single-element packet, idle, hold.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d wr_ready", i), 32'(wr_ready_s), 32'(vecs[i].ew));
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].el);
        end

        // Output stall: completing element waits, earlier ones flow in.
        for (int i = 1; i <= 4; i++) drive(4'(i), 1, 0, 0);
        check_out("stall load", 1, 16'h1234, 3'd4, 0);
        for (int i = 5; i <= 7; i++) begin
            drive(4'(i), 1, 0, 0);
            check($sformatf("stall elem%0d wr_ready", i), 32'(wr_ready_s), 32'd1);
            check_out($sformatf("stall elem%0d", i), 1, 16'h1234, 3'd4, 0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(4'h8, 1, 0, 0);
            check("stall elem8 wr_ready", 32'(wr_ready_s), 32'd0);
            check_out("stall held", 1, 16'h1234, 3'd4, 0);
        end
        drive(4'h8, 1, 0, 1);
        check("release wr_ready", 32'(wr_ready_s), 32'd1);
        check_out("release", 1, 16'h5678, 3'd4, 0);
        drive(4'h0, 0, 0, 1);
        check_out("release drain", 0, 16'h5678, 3'd4, 0);

        // Continuous 64-element stream.
        begin
            int words = 0;
            for (int i = 0; i < 64; i++) begin
                drive(4'(i), 1, 0, 1);
                check("stream wr_ready", 32'(wr_ready_s), 32'd1);
                check("stream rd_vld", 32'(bus.rd_vld), 32'((i % 4) == 3));
                if ((i % 4) == 3) begin
                    logic [15:0] exp_w;
                    exp_w = {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)};
                    check("stream rd_data", 32'(bus.rd_data), 32'(exp_w));
                    check("stream rd_cnt", 32'(bus.rd_cnt), 32'd4);
                end
                if (bus.rd_vld) words++;
            end
            drive(4'h0, 0, 0, 1);
            check("stream word count", 32'(words), 32'd16);
        end

        // Round trip from a serializer-style element stream.
        begin
            int got = 0;
            for (int w = 0; w < 7; w++) begin
                for (int j = 0; j < int'(src[w].cnt); j++) begin
                    logic [15:0] sw;
                    sw = src[w].data;
                    drive(sw[15-4*j -: 4], 1, (j == int'(src[w].cnt) - 1) && src[w].last, 1);
                    if (bus.rd_vld) begin
                        if (got < 7) check_out($sformatf("rt word%0d", got),
                                               1, src[got].data, src[got].cnt, src[got].last);
                        got++;
                    end
                end
            end
            drive(4'h0, 0, 0, 1);
            if (bus.rd_vld) begin
                if (got < 7) check_out($sformatf("rt word%0d", got),
                                       1, src[got].data, src[got].cnt, src[got].last);
                got++;
            end
            check("rt word count", 32'(got), 32'd7);
        end

        // Reset in the middle of a word.
        drive(4'h1, 1, 0, 1);
        drive(4'h2, 1, 0, 1);
        bus.wr_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out("mid reset", 0, 16'h0000, 3'd0, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        drive(4'h9, 1, 0, 1);
        check_out("post reset 9", 0, 16'h0000, 3'd0, 0);
        drive(4'hA, 1, 0, 1);
        check_out("post reset A", 0, 16'h0000, 3'd0, 0);
        drive(4'hB, 1, 0, 1);
        check_out("post reset B", 0, 16'h0000, 3'd0, 0);
        drive(4'hC, 1, 0, 1);
        check_out("post reset C", 1, 16'h9ABC, 3'd4, 0);
        drive(4'h0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/width_combine.md
Name: width_combine

Overview:
- Narrow-to-wide packer: gathers NSIZE consecutive DSIZE-bit elements from a valid/ready stream and emits one DSIZE*NSIZE-bit word.
- It is the receive-side counterpart of the width serializer on the same FIFO datapath, and restores words that were split into elements.
- A packet boundary (wr_last) flushes a partially filled word. The word carries an element count and a last flag.
- Sustains one element per cycle in and one word per NSIZE cycles out.

Parameters:
- DSIZE, 1, width of one input element in bits.
- NSIZE, 8, number of elements per output word. Legal range 2..255.
- Derived localparam PW = $clog2(NSIZE): lane pointer width.
- Derived localparam CW = $clog2(NSIZE+1): element count width.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_data  in  DSIZE  input element.
- wr_vld  in  1  input element valid.
- wr_ready  out  1  element accepted when wr_vld && wr_ready.
- wr_last  in  1  qualifies the accepted element as the last of its packet.
- rd_data  out  DSIZE*NSIZE  packed output word.
- rd_vld  out  1  output word valid.
- rd_last  out  1  word ends a packet.
- rd_cnt  out  CW  number of valid elements in rd_data, 1..NSIZE.
- rd_ready  in  1  downstream accepts the word when rd_vld && rd_ready.

Behaviour:
- Reset values: rd_data=0, rd_vld=0, rd_last=0, rd_cnt=0, point=0, accumulator=0. wr_ready is 1 one cycle after reset deassertion.
- Lane order is MSB-first. The element accepted at point p goes to bits [DSIZE*(NSIZE-p)-1 -: DSIZE], so the first element lands in the top lane.
- Internal state:
  - Accumulator register acc[DSIZE*NSIZE-1:0] and lane pointer point[PW-1:0].
  - A separate output register holds rd_data, rd_cnt and rd_last, so accumulation of the next word overlaps with output stall.
- accept = wr_vld && wr_ready.
- complete = accept && (point==NSIZE-1 || wr_last).
- wr_ready is combinational: wr_ready = !((point==NSIZE-1 || wr_last) && rd_vld && !rd_ready).
  - Elements that do not complete a word are never stalled.
  - The completing element stalls only while the output register is full and not draining.
- On accept && !complete:
  - Write the element into acc at lane point.
  - point <= point+1.
- On complete:
  - rd_data <= acc with the current element merged at lane point.
  - Lanes below point are forced to 0.
  - rd_cnt <= point+1.
  - rd_last <= wr_last.
  - rd_vld <= 1.
  - point <= 0 and acc <= 0.
- Latency: rd_vld rises on the cycle after the completing element is accepted.
- Output register rules:
  - If rd_vld && rd_ready and no complete in the same cycle: rd_vld <= 0 and rd_last <= 0. rd_data and rd_cnt hold their last value.
  - A drain and a complete in the same cycle load the new word and keep rd_vld=1. This gives zero bubble.
  - Output values are held stable while rd_vld && !rd_ready.
- Word is full with wr_last also set (point==NSIZE-1 && wr_last): emit a full word with rd_cnt=NSIZE and rd_last=1.
- wr_last at point==0: emit a single-element word with rd_cnt=1.
- wr_data and wr_last are ignored when wr_vld=0 or wr_ready=0.
- Reset asserted mid-word: the partial accumulator is discarded, all state returns to reset values, and no word is emitted.
- rd_ready may be high with rd_vld=0; this has no effect.

Test Plan:
- DSIZE=4, NSIZE=4, rd_ready=1; accept 1,2,3,4 on consecutive cycles, wr_last=0 -> one cycle later rd_vld=1, rd_data=16'h1234, rd_cnt=4, rd_last=0; wr_ready stays 1 throughout.
- Same config; accept 5,6 with wr_last on 6 -> rd_data=16'h5600, rd_cnt=2, rd_last=1; the next element starts a new word at the top lane.
- Same config; single element A with wr_last at point 0 -> rd_data=16'hA000, rd_cnt=1, rd_last=1.
- Same config; hold rd_ready=0 with word 16'h1234 pending, feed 5,6,7,8 -> 5,6,7 accepted, wr_ready=0 while 8 is offered, rd_data stable.
  - Then raise rd_ready -> 8 accepted in that same cycle and 16'h5678 appears on the next cycle with no gap.
- Continuous stream of 64 elements, rd_ready=1 -> 16 words, one every 4 cycles, wr_ready never low. Also round-trip through width_serializer -> width_combine with the data word, element count and last flag matching the source exactly.
- Assert rst_n=0 after accepting 2 elements -> all outputs reset values; after release, feed 9,A,B,C -> rd_data=16'h9ABC, rd_cnt=4.
